fp_alu_pipe: RTL and testbench



---
 rtl/fp_alu_pipe.sv | 278 +++++++++++++++++++++++++++
 tb/tb_fp_alu_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_pipe.sv
// Two-stage sign/EXP_W/MAN_W minifloat ALU (ADD, SUB, MUL, MIN, MAX) with valid/ready handshakes.
// Define FP_ALU_STICKY_FLAGS_EN to add the flags_sticky/flags_clear accumulator.
module fp_alu_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [2:0]           flags
`ifdef FP_ALU_STICKY_FLAGS_EN
  ,
  output logic [2:0]           flags_sticky,
  input  logic                 flags_clear
`endif
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int RW   = 2 * MAN_W + 2;  // significand work width, binary point at bit 2*MAN_W
  localparam int XW   = EXP_W + 8;      // signed exponent work width

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MIN = 3'b011;
  localparam logic [2:0] OP_MAX = 3'b100;

  localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]    EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]        CANON_NAN = {1'b0, EXP_ONES, {MAN_W{1'b1}}};
  localparam logic signed [XW-1:0] X_BIAS   = XW'(BIAS);
  localparam logic signed [XW-1:0] X_EXPMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] X_ZERO   = '0;

  // ---------------- handshake / stall control ----------------
  logic init_done_reg;
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_en, s2_en, accept;

  assign s2_en     = !s2_valid_reg || out_ready;
  assign s1_en     = !s1_valid_reg || s2_en;
  assign in_ready  = init_done_reg && s1_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid_reg;

  // ---------------- S1: unpack and classify ----------------
  logic [W-1:0]       opnd [2];
  logic [1:0]         sgn, is_zero, is_nan;
  logic [EXP_W-1:0]   ex [2];
  logic [MAN_W-1:0]   mn [2];

  assign opnd[0] = a;
  assign opnd[1] = b;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_unpack
    assign sgn[gi]     = opnd[gi][W-1];
    assign ex[gi]      = opnd[gi][W-2:MAN_W];
    assign is_zero[gi] = (ex[gi] == '0);
    assign is_nan[gi]  = (ex[gi] == EXP_ONES);
    // subnormal encodings collapse to signed zero
    assign mn[gi]      = is_zero[gi] ? '0 : opnd[gi][MAN_W-1:0];
  end

  logic [W-1:0]            fa, fb;
  logic [EXP_W+MAN_W-1:0]  mag_a, mag_b;
  logic                    a_lt_b, b_lt_a;
  logic                    sb_eff, swap, big_s, small_s;
  logic [EXP_W-1:0]        big_e, small_e, diff;
  logic [MAN_W-1:0]        big_m, small_m;
  logic [RW-1:0]           big_sig, small_sig, sum_sig, prod_sig;
  logic signed [XW-1:0]    mul_exp;

  assign fa    = {sgn[0], ex[0], mn[0]};
  assign fb    = {sgn[1], ex[1], mn[1]};
  assign mag_a = {ex[0], mn[0]};
  assign mag_b = {ex[1], mn[1]};

  always_comb begin
    a_lt_b = 1'b0;
    b_lt_a = 1'b0;
    if (sgn[0] != sgn[1]) begin
      a_lt_b = sgn[0];
      b_lt_a = sgn[1];
    end else if (!sgn[0]) begin
      a_lt_b = mag_a < mag_b;
      b_lt_a = mag_b < mag_a;
    end else begin
      a_lt_b = mag_a > mag_b;
      b_lt_a = mag_b > mag_a;
    end
  end

  // Add/sub: order by magnitude so the difference is never negative.
  assign sb_eff    = sgn[1] ^ (op == OP_SUB);
  assign swap      = mag_b > mag_a;
  assign big_s     = swap ? sb_eff : sgn[0];
  assign small_s   = swap ? sgn[0] : sb_eff;
  assign big_e     = swap ? ex[1] : ex[0];
  assign small_e   = swap ? ex[0] : ex[1];
  assign big_m     = swap ? mn[1] : mn[0];
  assign small_m   = swap ? mn[0] : mn[1];
  assign diff      = big_e - small_e;
  assign big_sig   = {1'b0, 1'b1, big_m, {MAN_W{1'b0}}};
  assign small_sig = {1'b0, 1'b1, small_m, {MAN_W{1'b0}}} >> diff;
  assign sum_sig   = (big_s == small_s) ? (big_sig + small_sig) : (big_sig - small_sig);

  assign prod_sig = {{(MAN_W+1){1'b0}}, 1'b1, mn[0]} * {{(MAN_W+1){1'b0}}, 1'b1, mn[1]};
  assign mul_exp  = $signed({{(XW-EXP_W){1'b0}}, ex[0]})
                  + $signed({{(XW-EXP_W){1'b0}}, ex[1]}) - X_BIAS;

  logic                 s1_bypass_reg, s1_bypass_next;
  logic [W-1:0]         s1_byp_y_reg, s1_byp_y_next;
  logic [2:0]           s1_byp_flags_reg, s1_byp_flags_next;
  logic                 s1_sign_reg, s1_sign_next;
  logic signed [XW-1:0] s1_exp_reg, s1_exp_next;
  logic [RW-1:0]        s1_sig_reg, s1_sig_next;

  always_comb begin
    s1_bypass_next    = 1'b0;
    s1_byp_y_next     = '0;
    s1_byp_flags_next = 3'b000;
    s1_sign_next      = 1'b0;
    s1_exp_next       = '0;
    s1_sig_next       = '0;
    if (op > OP_MAX) begin
      s1_bypass_next    = 1'b1;
      s1_byp_flags_next = 3'b100;
    end else if (|is_nan) begin
      s1_bypass_next    = 1'b1;
      s1_byp_y_next     = CANON_NAN;
      s1_byp_flags_next = 3'b100;
    end else begin
      case (op)
        OP_MIN: begin
          s1_bypass_next = 1'b1;
          s1_byp_y_next  = b_lt_a ? fb : fa;
        end
        OP_MAX: begin
          s1_bypass_next = 1'b1;
          s1_byp_y_next  = a_lt_b ? fb : fa;
        end
        OP_MUL: begin
          if (|is_zero) begin
            s1_bypass_next = 1'b1;
            s1_byp_y_next  = {sgn[0] ^ sgn[1], {(W-1){1'b0}}};
          end else begin
            s1_sign_next = sgn[0] ^ sgn[1];
            s1_exp_next  = mul_exp;
            s1_sig_next  = prod_sig;
          end
        end
        default: begin  // ADD / SUB
          if (is_zero[1]) begin
            s1_bypass_next = 1'b1;
            s1_byp_y_next  = fa;
          end else if (is_zero[0]) begin
            s1_bypass_next = 1'b1;
            s1_byp_y_next  = {sb_eff, ex[1], mn[1]};
          end else begin
            // exact cancellation yields +0
            s1_sign_next = (sum_sig == '0) ? 1'b0 : big_s;
            s1_exp_next  = $signed({{(XW-EXP_W){1'b0}}, big_e});
            s1_sig_next  = sum_sig;
          end
        end
      endcase
    end
  end

  // ---------------- S2: normalise, truncate, pack ----------------
  int                   lead_pos;
  int                   norm_shift;
  logic [RW-1:0]        norm_sig;
  logic signed [XW-1:0] norm_exp;
  logic [W-1:0]         y_reg, y_next;
  logic [2:0]           flags_reg, flags_next;

  always_comb begin
    lead_pos = 0;
    for (int i = 0; i < RW - 1; i++) begin
      if (s1_sig_reg[i]) lead_pos = i;
    end
    norm_shift = (RW - 2) - lead_pos;
    if (s1_sig_reg[RW-1]) begin
      norm_sig = s1_sig_reg >> 1;
      norm_exp = s1_exp_reg + XW'(1);
    end else begin
      norm_sig = s1_sig_reg << norm_shift;
      norm_exp = s1_exp_reg - XW'(norm_shift);
    end
  end

  always_comb begin
    y_next     = '0;
    flags_next = 3'b000;
    if (s1_bypass_reg) begin
      y_next     = s1_byp_y_reg;
      flags_next = s1_byp_flags_reg;
    end else if (s1_sig_reg == '0) begin
      y_next = {s1_sign_reg, {(W-1){1'b0}}};
    end else if (norm_exp >= X_EXPMAX) begin
      y_next     = {s1_sign_reg, EXP_MAXF, {MAN_W{1'b1}}};
      flags_next = 3'b010;
    end else if (norm_exp <= X_ZERO) begin
      y_next     = {s1_sign_reg, {(W-1){1'b0}}};
      flags_next = 3'b001;
    end else begin
      y_next = {s1_sign_reg, norm_exp[EXP_W-1:0], norm_sig[RW-3 -: MAN_W]};
    end
  end

  // hidden bit, carry slot and truncated tail are dropped by design
  logic unused_norm_bits;
  assign unused_norm_bits = ^{norm_sig[RW-1:RW-2], norm_sig[MAN_W-1:0]};

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_done_reg    <= 1'b0;
      s1_valid_reg     <= 1'b0;
      s2_valid_reg     <= 1'b0;
      s1_bypass_reg    <= 1'b0;
      s1_byp_y_reg     <= '0;
      s1_byp_flags_reg <= 3'b000;
      s1_sign_reg      <= 1'b0;
      s1_exp_reg       <= '0;
      s1_sig_reg       <= '0;
      y_reg            <= '0;
      flags_reg        <= 3'b000;
    end else begin
      init_done_reg <= 1'b1;
      if (s1_en) s1_valid_reg <= accept;
      if (accept) begin
        s1_bypass_reg    <= s1_bypass_next;
        s1_byp_y_reg     <= s1_byp_y_next;
        s1_byp_flags_reg <= s1_byp_flags_next;
        s1_sign_reg      <= s1_sign_next;
        s1_exp_reg       <= s1_exp_next;
        s1_sig_reg       <= s1_sig_next;
      end
      if (s2_en) s2_valid_reg <= s1_valid_reg;
      if (s2_en && s1_valid_reg) begin
        y_reg     <= y_next;
        flags_reg <= flags_next;
      end
    end
  end

  assign y     = y_reg;
  assign flags = flags_reg;

`ifdef FP_ALU_STICKY_FLAGS_EN
  logic out_fire;
  assign out_fire = s2_valid_reg && out_ready;

  // a bit raised by a handshake beats a simultaneous clear
  for (gi = 0; gi < 3; gi++) begin : g_sticky
    logic bit_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                         bit_reg <= 1'b0;
      else if (out_fire && flags_reg[gi]) bit_reg <= 1'b1;
      else if (flags_clear)              bit_reg <= 1'b0;
    end
    assign flags_sticky[gi] = bit_reg;
  end
`endif

endmodule

// File: tb/tb_fp_alu_pipe.sv
// Directed self-checking bench for fp_alu_pipe at EXP_W=4, MAN_W=3 (e4m3, bias 7).
// Sticky-flag checks are compiled in when FP_ALU_STICKY_FLAGS_EN is defined.
module tb_fp_alu_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [2:0] flags;
`ifdef FP_ALU_STICKY_FLAGS_EN
  logic [2:0] flags_sticky;
  logic       flags_clear;
`endif

  int compared   = 0;
  int mismatched = 0;

  fp_alu_pipe #(.EXP_W(4), .MAN_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .flags       (flags)
`ifdef FP_ALU_STICKY_FLAGS_EN
    ,
    .flags_sticky(flags_sticky),
    .flags_clear (flags_clear)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op into an idle pipeline with out_ready=1; check latency and result.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb2,
                        input logic [2:0] top, input logic [7:0] ey, input logic [2:0] ef);
    a = ta; b = tb2; op = top; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_y"}, y, ey);
    check({tag, "_flags"}, flags, ef);
    $display("%-10s op=%b a=%h b=%h -> y=%h flags=%b (want y=%h flags=%b)",
             tag, top, ta, tb2, y, flags, ey, ef);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
`ifdef FP_ALU_STICKY_FLAGS_EN
    flags_clear = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 8'h00);
    check("rst_flags", flags, 3'b000);
`ifdef FP_ALU_STICKY_FLAGS_EN
    check("rst_sticky", flags_sticky, 3'b000);
`endif
    reset = 1'b0;
    #1;
    check("rdy_before_edge", in_ready, 0);
    step();
    check("rdy_after_edge", in_ready, 1);

    // Directed arithmetic vectors.
    run_op("add_1p1",   8'h38, 8'h38, 3'b000, 8'h40, 3'b000);
    run_op("sub_cancel",8'h38, 8'h38, 3'b001, 8'h00, 3'b000);
    run_op("add_trunc", 8'h38, 8'h18, 3'b000, 8'h38, 3'b000);
    run_op("sub_neg",   8'h38, 8'h40, 3'b001, 8'hB8, 3'b000);
    run_op("mul_1p5sq", 8'h3C, 8'h3C, 3'b010, 8'h41, 3'b000);
    run_op("mul_ovf",   8'h77, 8'h40, 3'b010, 8'h77, 3'b010);
    run_op("add_ovf",   8'h77, 8'h77, 3'b000, 8'h77, 3'b010);
    run_op("mul_unf",   8'h08, 8'h08, 3'b010, 8'h00, 3'b001);
    run_op("mul_zero",  8'hB8, 8'h00, 3'b010, 8'h80, 3'b000);
    run_op("add_xp0",   8'h45, 8'h80, 3'b000, 8'h45, 3'b000);
    run_op("sub_0mx",   8'h00, 8'hC5, 3'b001, 8'h45, 3'b000);
    run_op("add_nan",   8'h7F, 8'h38, 3'b000, 8'h7F, 3'b100);
    run_op("illegal",   8'h38, 8'h38, 3'b111, 8'h00, 3'b100);
    run_op("min_zeros", 8'h80, 8'h00, 3'b011, 8'h80, 3'b000);
    run_op("max_mix",   8'hC0, 8'h38, 3'b100, 8'h38, 3'b000);
    run_op("min_eq",    8'h00, 8'h00, 3'b011, 8'h00, 3'b000);
    step();

`ifdef FP_ALU_STICKY_FLAGS_EN
    flags_clear = 1'b1;
    step();
    flags_clear = 1'b0;
    check("sticky_cleared", flags_sticky, 3'b000);
    run_op("stk_ovf", 8'h77, 8'h40, 3'b010, 8'h77, 3'b010);
    run_op("stk_nan", 8'h7F, 8'h38, 3'b000, 8'h7F, 3'b100);
    step();
    check("sticky_110", flags_sticky, 3'b110);
    run_op("stk_unf", 8'h08, 8'h08, 3'b010, 8'h00, 3'b001);
    flags_clear = 1'b1;
    step();
    flags_clear = 1'b0;
    check("sticky_set_wins", flags_sticky, 3'b001);
`endif

    // Back-pressure: two results held, then drain in order.
    out_ready = 1'b0;
    a = 8'h38; b = 8'h38; op = 3'b000; in_valid = 1'b1;
    #1;
    check("stall_rdy0", in_ready, 1);
    step();
    check("stall_ov0", out_valid, 0);
    a = 8'h3C; b = 8'h3C; op = 3'b010;
    #1;
    check("stall_rdy1", in_ready, 1);
    step();
    check("stall_ov1", out_valid, 1);
    check("stall_y_first", y, 8'h40);
    check("stall_full", in_ready, 0);
    a = 8'h38; b = 8'h40; op = 3'b001;
    step();
    check("stall_hold_rdy", in_ready, 0);
    check("stall_hold_y1", y, 8'h40);
    step();
    check("stall_hold_y2", y, 8'h40);
    check("stall_hold_ov", out_valid, 1);
    $display("stall      held y=%h in_ready=%b", y, in_ready);
    out_ready = 1'b1;
    #1;
    check("comb_ready", in_ready, 1);
    step();
    check("drain_y1", y, 8'h41);
    check("drain_ov1", out_valid, 1);
    $display("drain      y=%h", y);
    a = 8'h80; b = 8'h00; op = 3'b011;
    step();
    in_valid = 1'b0;
    check("drain_y2", y, 8'hB8);
    check("drain_ov2", out_valid, 1);
    $display("drain      y=%h", y);
    step();
    check("drain_y3", y, 8'h80);
    check("drain_ov3", out_valid, 1);
    $display("drain      y=%h", y);
    step();
    check("drain_empty", out_valid, 0);

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    a = 8'h38; b = 8'h38; op = 3'b000; in_valid = 1'b1;
    step();
    a = 8'h3C; b = 8'h3C; op = 3'b010;
    step();
    in_valid = 1'b0;
    check("inflight_ov", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_ov", out_valid, 0);
    check("async_rst_y", y, 8'h00);
    $display("reset      mid-cycle out_valid=%b y=%h", out_valid, y);
    #2;
    reset = 1'b0;
    #1;
    check("rel_rdy_pre", in_ready, 0);
    step();
    check("rel_rdy_post", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_ghost", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
